// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file between port A (ALU writeback)
// and port B (load unit / debug); one access per IDLE -> ACCESS -> DONE pass.
module regfile_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          rf_write_en,
    output logic          rf_out_en,
    output logic [AW-1:0] rf_sel,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_r;
    logic          last_grant_r;   // 1'b1 = port B was granted last
    logic          op_port_r;      // 1'b1 = current operation belongs to port B
    logic          op_we_r;
    logic          wr_phase_r;
    logic          rd_phase_r;
    logic          a_ack_r;
    logic          b_ack_r;
    logic          busy_r;
    logic [DW-1:0] a_rdata_r;
    logic [DW-1:0] b_rdata_r;
    logic [AW-1:0] rf_sel_r;
    logic [DW-1:0] rf_data_in_r;

    logic          any_req_s;
    logic          grant_a_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

    // Winner selection: a lone requester wins, contention goes to the port not granted last.
    always_comb begin
        any_req_s = a_req | b_req;
        if (a_req && b_req) begin
            grant_a_s = last_grant_r;
        end else begin
            grant_a_s = a_req;
        end
        if (grant_a_s) begin
            win_we_s    = a_we;
            win_addr_s  = a_addr;
            win_wdata_s = a_wdata;
        end else begin
            win_we_s    = b_we;
            win_addr_s  = b_addr;
            win_wdata_s = b_wdata;
        end
    end

    // Access sequencer: grant and latch op in IDLE, drive the file in ACCESS, acknowledge in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            op_port_r    <= 1'b0;
            op_we_r      <= 1'b0;
            wr_phase_r   <= 1'b0;
            rd_phase_r   <= 1'b0;
            a_ack_r      <= 1'b0;
            b_ack_r      <= 1'b0;
            busy_r       <= 1'b0;
            a_rdata_r    <= {DW{1'b0}};
            b_rdata_r    <= {DW{1'b0}};
            rf_sel_r     <= {AW{1'b0}};
            rf_data_in_r <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    if (any_req_s) begin
                        state_r      <= ACCESS;
                        busy_r       <= 1'b1;
                        last_grant_r <= ~grant_a_s;
                        op_port_r    <= ~grant_a_s;
                        op_we_r      <= win_we_s;
                        wr_phase_r   <= win_we_s;
                        rd_phase_r   <= ~win_we_s;
                        rf_sel_r     <= win_addr_s;
                        rf_data_in_r <= win_wdata_s;
                    end else begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        wr_phase_r <= 1'b0;
                        rd_phase_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    state_r    <= DONE;
                    wr_phase_r <= 1'b0;
                    rd_phase_r <= 1'b0;
                    a_ack_r    <= ~op_port_r;
                    b_ack_r    <= op_port_r;
                    // Read data is only valid while rf_out_en is high, i.e. in this cycle.
                    if (!op_we_r && !op_port_r) begin
                        a_rdata_r <= rf_data_out;
                    end else if (!op_we_r && op_port_r) begin
                        b_rdata_r <= rf_data_out;
                    end else begin
                        a_rdata_r <= a_rdata_r;
                        b_rdata_r <= b_rdata_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    wr_phase_r <= 1'b0;
                    rd_phase_r <= 1'b0;
                    a_ack_r    <= 1'b0;
                    b_ack_r    <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Enables are gated by rst combinationally so a reset landing on ACCESS never writes.
    assign rf_write_en = wr_phase_r & ~rst;
    assign rf_out_en   = rd_phase_r & ~rst;
    assign rf_sel      = rf_sel_r;
    assign rf_data_in  = rf_data_in_r;
    assign a_ack       = a_ack_r;
    assign b_ack       = b_ack_r;
    assign a_rdata     = a_rdata_r;
    assign b_rdata     = b_rdata_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a register-file stand-in, a transaction-timing model
// checked every cycle, and hand-computed expectations for each scenario.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic       rf_write_en, rf_out_en;
    logic [2:0] rf_sel;
    logic [7:0] rf_data_in, rf_data_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    regfile_arbiter #(.DW(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_write_en(rf_write_en), .rf_out_en(rf_out_en), .rf_sel(rf_sel),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file stand-in driven only through the arbiter.
    logic [7:0] rf_mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    assign rf_data_out = rf_out_en ? rf_mem[rf_sel] : 8'h00;
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_sel] <= rf_data_in;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a grant at posedge g means access after g, ack after g+1, idle after g+2.
    int         cyc = 0;
    bit         m_active = 1'b0;
    int         m_g = 0;
    bit         m_last = 1'b1;
    bit         m_win = 1'b0;
    bit         m_we = 1'b0;
    logic [2:0] m_addr = 3'd0;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_wd = 8'h00;
    logic [7:0] m_din = 8'h00;
    logic [7:0] m_ard = 8'h00;
    logic [7:0] m_brd = 8'h00;
    logic [7:0] m_regs [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

    always @(posedge clk) begin
        int  age;
        bit  pick_b;
        age = m_active ? (cyc - 1 - m_g) : 99;
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_last   <= 1'b1;
            m_sel    <= 3'd0;
            m_din    <= 8'h00;
            m_ard    <= 8'h00;
            m_brd    <= 8'h00;
        end else begin
            if (age == 0) begin
                if (m_we) m_regs[m_addr] <= m_wd;
                else if (!m_win) m_ard <= m_regs[m_addr];
                else m_brd <= m_regs[m_addr];
            end
            if (age >= 2 && (a_req || b_req)) begin
                pick_b = b_req && !(a_req && m_last);
                m_active <= 1'b1;
                m_g      <= cyc;
                m_win    <= pick_b;
                m_last   <= pick_b;
                m_we     <= pick_b ? b_we : a_we;
                m_addr   <= pick_b ? b_addr : a_addr;
                m_wd     <= pick_b ? b_wdata : a_wdata;
                m_sel    <= pick_b ? b_addr : a_addr;
                m_din    <= pick_b ? b_wdata : a_wdata;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        int age;
        if (chk_en) begin
            age = m_active ? (cyc - 1 - m_g) : 99;
            cmp("busy",        32'(busy),        32'(age == 0 || age == 1));
            cmp("a_ack",       32'(a_ack),       32'(age == 1 && !m_win));
            cmp("b_ack",       32'(b_ack),       32'(age == 1 && m_win));
            cmp("rf_write_en", 32'(rf_write_en), 32'(age == 0 && m_we && !rst));
            cmp("rf_out_en",   32'(rf_out_en),   32'(age == 0 && !m_we && !rst));
            cmp("rf_sel",      32'(rf_sel),      32'(m_sel));
            cmp("rf_data_in",  32'(rf_data_in),  32'(m_din));
            cmp("a_rdata",     32'(a_rdata),     32'(m_ard));
            cmp("b_rdata",     32'(b_rdata),     32'(m_brd));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [2:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [2:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic wait_ack(input bit port_b, output int lat);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (port_b ? b_ack : a_ack) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, a_at, b_at, wcnt, n;
        int ack_step [8];
        int ack_port [8];

        rst = 1'b1;
        set_a(1'b0, 1'b0, 3'd0, 8'h00);
        set_b(1'b0, 1'b0, 3'd0, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        chk_en = 1'b1;
        cmp("rst_busy",   32'(busy), 32'd0);
        cmp("rst_a_ack",  32'(a_ack), 32'd0);
        cmp("rst_b_ack",  32'(b_ack), 32'd0);
        cmp("rst_a_rdata", 32'(a_rdata), 32'd0);
        cmp("rst_b_rdata", 32'(b_rdata), 32'd0);
        cmp("rst_rf_sel", 32'(rf_sel), 32'd0);
        cmp("rst_rf_din", 32'(rf_data_in), 32'd0);
        cmp("rst_wen",    32'(rf_write_en), 32'd0);
        cmp("rst_oen",    32'(rf_out_en), 32'd0);
        rst = 1'b0;

        // 1: A writes r3=0x5A, then B reads it back.
        set_a(1'b1, 1'b1, 3'd3, 8'h5A);
        wait_ack(1'b0, lat);
        cmp("t1_a_latency", 32'(lat), 32'd2);
        a_req = 1'b0;
        step();
        set_b(1'b1, 1'b0, 3'd3, 8'h00);
        wait_ack(1'b1, lat);
        cmp("t1_b_latency", 32'(lat), 32'd2);
        cmp("t1_b_rdata", 32'(b_rdata), 32'h5A);
        cmp("t1_a_rdata", 32'(a_rdata), 32'h00);
        b_req = 1'b0;
        step();

        // 2: contention right after reset, both write r1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_a(1'b1, 1'b1, 3'd1, 8'h11);
        set_b(1'b1, 1'b1, 3'd1, 8'h22);
        a_at = 0; b_at = 0; wcnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (rf_write_en) wcnt++;
            if (a_ack) begin a_at = i; a_req = 1'b0; end
            if (b_ack) begin b_at = i; b_req = 1'b0; end
        end
        cmp("t2_a_ack_step", 32'(a_at), 32'd2);
        cmp("t2_b_ack_step", 32'(b_at), 32'd5);
        cmp("t2_wen_cycles", 32'(wcnt), 32'd2);
        cmp("t2_r1_final", 32'(rf_mem[1]), 32'h22);

        // 3: both read continuously for 12 cycles.
        set_a(1'b1, 1'b0, 3'd1, 8'h00);
        set_b(1'b1, 1'b0, 3'd3, 8'h00);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a_ack && b_ack) cmp("t3_both_ack", 32'd1, 32'd0);
            if ((a_ack || b_ack) && n < 8) begin
                ack_step[n] = i;
                ack_port[n] = int'(b_ack);
                n++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        cmp("t3_ack_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("t3_ack%0d_step", k), 32'(ack_step[k]), 32'(2 + 3 * k));
            cmp($sformatf("t3_ack%0d_port", k), 32'(ack_port[k]), 32'(k % 2));
        end
        cmp("t3_a_rdata", 32'(a_rdata), 32'h22);
        cmp("t3_b_rdata", 32'(b_rdata), 32'h5A);
        step();

        // 4: reset lands on the ACCESS cycle of a B write to r7.
        set_b(1'b1, 1'b1, 3'd7, 8'hFF);
        step();
        cmp("t4_wen_before_rst", 32'(rf_write_en), 32'd1);
        rst = 1'b1;
        #1;
        cmp("t4_wen_in_rst", 32'(rf_write_en), 32'd0);
        b_req = 1'b0;
        step();
        cmp("t4_busy_after", 32'(busy), 32'd0);
        cmp("t4_no_ack", 32'(b_ack), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("t4_no_late_ack", 32'(b_ack), 32'd0);
        end
        cmp("t4_r7_kept", 32'(rf_mem[7]), 32'h17);

        // 5: A reads r0; address changes after grant are ignored.
        set_a(1'b1, 1'b0, 3'd0, 8'h00);
        step();
        a_addr = 3'd5;
        cmp("t5_rf_sel", 32'(rf_sel), 32'd0);
        cmp("t5_oen", 32'(rf_out_en), 32'd1);
        step();
        cmp("t5_a_ack", 32'(a_ack), 32'd1);
        cmp("t5_a_rdata", 32'(a_rdata), 32'h10);
        a_req = 1'b0;
        step();

        // 6: idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            cmp("t6_busy", 32'(busy), 32'd0);
            cmp("t6_wen", 32'(rf_write_en), 32'd0);
            cmp("t6_oen", 32'(rf_out_en), 32'd0);
            cmp("t6_ack", 32'(a_ack | b_ack), 32'd0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
